ddr_cmd_arb: RTL

- Shares one DDR read/write command FIFO (64-bit datamover-style commands) between up to NUM_REQ requesters, e.g. PIL playback reader, ADC capture writer and debug dump.
- Arbitrates round-robin and stamps each issued command with a requester tag.
- Tracks outstanding commands per requester against returned status tags, so no requester can hog the datamover queue.
- Sits between the per-function command generators and the single cmd FIFO in front of the datamover.

---
 rtl/ddr_cmd_pkg.sv | 31 +++
 rtl/ddr_cmd_arb_rr_arbiter.sv | 31 +++
 rtl/ddr_cmd_arb.sv | 112 +++++++++++
 3 files changed

// File: rtl/ddr_cmd_pkg.sv
// Shared command-format constants and helpers for the DDR command arbiter.
// Commands follow the datamover layout: BTT low, address high, tag carved out of the address.
package ddr_cmd_pkg;

    localparam int CMD_W    = 64;
    localparam int BTT_LSB  = 0;
    localparam int BTT_W    = 23;
    localparam int ADDR_LSB = 32;
    localparam int ADDR_MSB = 63;
    localparam int TAG_LSB  = 60;
    localparam int TAG_W    = 3;

    typedef enum logic [TAG_W-1:0] {
        PIL_RD = 3'd0,
        ADC_WR = 3'd1,
        DBG    = 3'd2,
        SPARE  = 3'd3
    } req_id_e;

    function automatic logic [CMD_W-1:0] insert_tag(
        input logic [CMD_W-1:0] cmd,
        input logic [TAG_W-1:0] tag,
        input int               lsb
    );
        logic [CMD_W-1:0] r;
        r = cmd;
        r[lsb +: TAG_W] = tag;
        return r;
    endfunction

endpackage

// File: rtl/ddr_cmd_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Produces both a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_cmd_arb.sv
// Round-robin sharing of one datamover cmd FIFO between NUM_REQ requesters,
// with per-requester tag stamping and outstanding-command limiting.
//   state   | meaning
//   ST_ARB  | looking for an eligible requester while the FIFO has room
//   ST_GAP  | one idle cycle after an issue so the requester can update valid
module ddr_cmd_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_OUTST = 4,
    parameter int TAG_LSB   = ddr_cmd_pkg::TAG_LSB
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [ddr_cmd_pkg::CMD_W*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [ddr_cmd_pkg::CMD_W-1:0]       fifo_din_cmd,
    output logic                                fifo_wr_en_cmd,
    input  logic                                fifo_full_cmd,
    input  logic                                sts_valid,
    input  logic [ddr_cmd_pkg::TAG_W-1:0]       sts_tag,
    output logic [4*NUM_REQ-1:0]                outst_cnt,
    output logic                                busy,
    output logic                                err_sts
);
    import ddr_cmd_pkg::*;

    localparam int         IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;
    localparam logic [3:0] CNT_MAX = 4'(MAX_OUTST);

    logic [0:0]               state;
    logic [IW-1:0]            rr_ptr;
    logic [NUM_REQ-1:0][3:0]  cnt;
    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       gnt;
    logic [IW-1:0]            gnt_idx;
    logic                     gnt_any;
    logic                     grant;
    logic                     sts_bad;
    logic [CMD_W-1:0]         win_cmd;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < CNT_MAX);
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign grant = (state == ST_ARB) && !fifo_full_cmd && gnt_any;

    always_comb begin
        win_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) win_cmd = req_cmd[i*CMD_W +: CMD_W];
        end
    end

    // A status is bad if its tag has no requester or that requester has nothing in flight.
    always_comb begin
        sts_bad = sts_valid && (int'(sts_tag) >= NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sts_valid && sts_tag == TAG_W'(i) && cnt[i] == 4'd0) sts_bad = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_ARB;
            rr_ptr         <= '0;
            cnt            <= '0;
            req_ready      <= '0;
            fifo_din_cmd   <= '0;
            fifo_wr_en_cmd <= 1'b0;
            busy           <= 1'b0;
            err_sts        <= 1'b0;
        end else begin
            req_ready      <= grant ? gnt : '0;
            fifo_wr_en_cmd <= grant;
            busy           <= (|cnt) || (state == ST_GAP);
            if (sts_bad) err_sts <= 1'b1;
            if (grant) begin
                fifo_din_cmd <= insert_tag(win_cmd, TAG_W'(gnt_idx), TAG_LSB);
                rr_ptr       <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                state        <= ST_GAP;
            end else begin
                state        <= ST_ARB;
            end
            // Issue and retire on the same requester cancel out.
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((grant && gnt[i]) &&
                    !(sts_valid && sts_tag == TAG_W'(i) && cnt[i] != 4'd0)) begin
                    cnt[i] <= cnt[i] + 4'd1;
                end else if (!(grant && gnt[i]) &&
                             (sts_valid && sts_tag == TAG_W'(i) && cnt[i] != 4'd0)) begin
                    cnt[i] <= cnt[i] - 4'd1;
                end
            end
        end
    end

    assign outst_cnt = cnt;

endmodule
